// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU Avalon-MM front-end.
// Holds the region codes, the CSR indices and bit positions, the sequencer state
// encoding and the ID register constant.
package tpu_pkg;

    // Region codes, taken from the top two bits of the word address
    localparam logic [1:0] REGION_CSR    = 2'b00;
    localparam logic [1:0] REGION_WEIGHT = 2'b01;
    localparam logic [1:0] REGION_INPUT  = 2'b10;
    localparam logic [1:0] REGION_OUTPUT = 2'b11;

    // CSR word indices
    localparam logic [2:0] CSR_CTRL     = 3'd0;
    localparam logic [2:0] CSR_STATUS   = 3'd1;
    localparam logic [2:0] CSR_BASE_W   = 3'd2;
    localparam logic [2:0] CSR_BASE_IN  = 3'd3;
    localparam logic [2:0] CSR_BASE_OUT = 3'd4;
    localparam logic [2:0] CSR_ID       = 3'd5;

    // CTRL bits
    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_ABORT_BIT  = 2;

    // STATUS bits
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;
    localparam int unsigned STAT_ERR_BIT   = 2;
    localparam int unsigned STAT_STATE_LSB = 3;

    localparam logic [15:0] ID_MAGIC = 16'h7E50;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLdW   = 3'd1,
        StLdIn  = 3'd2,
        StMult  = 3'd3,
        StDrain = 3'd4
    } tpu_seq_state_t;

    function automatic logic [31:0] id_word(input int unsigned dim);
        return {ID_MAGIC, 16'(dim)};
    endfunction

endpackage

// File: rtl/tpu_avalon_ctrl_if.sv
// Avalon-MM bus bundle between the host and the TPU front-end.
// Signals: slave_address (word address), slave_read / slave_write strobes,
// slave_writedata, slave_byteenable, slave_readdata (latency 1).
// Modports: master drives the request side, slave returns slave_readdata.
interface tpu_avalon_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]   slave_address;
    logic                    slave_read;
    logic                    slave_write;
    logic [DATA_WIDTH-1:0]   slave_writedata;
    logic [DATA_WIDTH/8-1:0] slave_byteenable;
    logic [DATA_WIDTH-1:0]   slave_readdata;

    modport master (
        output slave_address,
        output slave_read,
        output slave_write,
        output slave_writedata,
        output slave_byteenable,
        input  slave_readdata
    );

    modport slave (
        input  slave_address,
        input  slave_read,
        input  slave_write,
        input  slave_writedata,
        input  slave_byteenable,
        output slave_readdata
    );
endinterface

// File: rtl/tpu_seq_fsm.sv
// Start/done sequencer for a DIM x DIM systolic array.
// Ports: clk, reset (async, active low); start, abort requests in; state, busy,
// done_set (one-cycle pulse on DRAIN exit) and the registered strobes
// ld_weights, ld_fifo, mult_en out.
// Phase lengths: LD_W DIM, LD_IN DIM, MULT 2*DIM, DRAIN DIM cycles, timed by one
// down-counter reloaded on every state entry.
module tpu_seq_fsm
    import tpu_pkg::*;
#(
    parameter int unsigned DIM = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    output tpu_seq_state_t state,
    output logic           busy,
    output logic           done_set,
    output logic           ld_weights,
    output logic           ld_fifo,
    output logic           mult_en
);
    localparam int unsigned CNT_W = $clog2(2 * DIM + 1);
    localparam logic [CNT_W-1:0] LEN_DIM  = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] LEN_MULT = CNT_W'(2 * DIM - 1);

    tpu_seq_state_t   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ld_w_q;
    logic             ld_f_q;
    logic             mult_q;
    logic             last;

    assign last = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ld_w_q  <= 1'b0;
            ld_f_q  <= 1'b0;
            mult_q  <= 1'b0;
        end else if (abort) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ld_w_q  <= 1'b0;
            ld_f_q  <= 1'b0;
            mult_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLdW;
                        cnt_q   <= LEN_DIM;
                        ld_w_q  <= 1'b1;
                    end
                end
                StLdW: begin
                    if (last) begin
                        state_q <= StLdIn;
                        cnt_q   <= LEN_DIM;
                        ld_w_q  <= 1'b0;
                        ld_f_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StLdIn: begin
                    if (last) begin
                        state_q <= StMult;
                        cnt_q   <= LEN_MULT;
                        ld_f_q  <= 1'b0;
                        mult_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StMult: begin
                    if (last) begin
                        state_q <= StDrain;
                        cnt_q   <= LEN_DIM;
                        mult_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StDrain: begin
                    if (last) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    ld_w_q  <= 1'b0;
                    ld_f_q  <= 1'b0;
                    mult_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign busy       = (state_q != StIdle);
    // Abort suppresses completion even on the final DRAIN cycle
    assign done_set   = (state_q == StDrain) && last && !abort;
    assign ld_weights = ld_w_q;
    assign ld_fifo    = ld_f_q;
    assign mult_en    = mult_q;
endmodule

// File: rtl/tpu_avalon_ctrl.sv
// Avalon-MM slave front-end for the systolic TPU core.
// Ports: clk, reset (async, active low); bus (Avalon slave modport); irq;
// weight/input write strobes with shared wr_addr/wr_data/wr_be; output memory
// read strobe rd_en_output, rd_addr and returned rd_data_output; CSR base
// addresses; sequencer strobes ld_weights, ld_fifo, mult_en.
// Holds region decode, CSRs and the read-data mux; sequencing lives in tpu_seq_fsm.
module tpu_avalon_ctrl
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIM        = 8,
    parameter int unsigned BANK_AW    = ADDR_WIDTH - 2
) (
    input  logic                    clk,
    input  logic                    reset,
    tpu_avalon_ctrl_if.slave        bus,
    output logic                    irq,
    output logic                    wr_en_weights,
    output logic                    wr_en_input,
    output logic [BANK_AW-1:0]      wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    rd_en_output,
    output logic [BANK_AW-1:0]      rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data_output,
    output logic [BANK_AW-1:0]      base_addr_weights,
    output logic [BANK_AW-1:0]      base_addr_input,
    output logic [BANK_AW-1:0]      base_addr_output,
    output logic                    ld_weights,
    output logic                    ld_fifo,
    output logic                    mult_en
);
    logic [1:0]            region;
    logic [2:0]            csr_idx;
    logic                  csr_wr, ctrl_wr, status_wr;
    logic                  start_req, abort_req, start_acc;
    logic                  mem_wr, err_set;
    logic                  busy, done_set;
    tpu_seq_state_t        seq_state;
    logic [BANK_AW-1:0]    lane_mask, wd_bank;
    logic [DATA_WIDTH-1:0] csr_rdata;

    logic                  irq_en_q, done_q, err_q;
    logic [BANK_AW-1:0]    base_w_q, base_in_q, base_out_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  out_sel_q;

    assign region    = bus.slave_address[ADDR_WIDTH-1 -: 2];
    assign csr_idx   = bus.slave_address[2:0];
    assign csr_wr    = bus.slave_write && (region == REGION_CSR);
    assign ctrl_wr   = csr_wr && (csr_idx == CSR_CTRL) && bus.slave_byteenable[0];
    assign status_wr = csr_wr && (csr_idx == CSR_STATUS) && bus.slave_byteenable[0];
    assign start_req = ctrl_wr && bus.slave_writedata[CTRL_START_BIT];
    assign abort_req = ctrl_wr && bus.slave_writedata[CTRL_ABORT_BIT];
    assign start_acc = start_req && !abort_req && !busy;
    assign mem_wr    = bus.slave_write &&
                       ((region == REGION_WEIGHT) || (region == REGION_INPUT));
    assign err_set   = (start_req && !abort_req && busy) || (mem_wr && busy);

    // Memory-side strobes are combinational so writes need no wait-state
    assign wr_en_weights = bus.slave_write && (region == REGION_WEIGHT) && !busy;
    assign wr_en_input   = bus.slave_write && (region == REGION_INPUT) && !busy;
    assign wr_addr       = bus.slave_address[BANK_AW-1:0];
    assign wr_data       = bus.slave_writedata;
    assign wr_be         = bus.slave_byteenable;
    assign rd_en_output  = bus.slave_read && (region == REGION_OUTPUT);
    assign rd_addr       = bus.slave_address[BANK_AW-1:0];

    // Per-bit mask of the byte lanes that cover a BANK_AW-wide base register
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < int'(BANK_AW); i++) begin
            lane_mask[i] = bus.slave_byteenable[i / 8];
        end
    end
    assign wd_bank = bus.slave_writedata[BANK_AW-1:0];

    tpu_seq_fsm #(
        .DIM (DIM)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .start      (start_acc),
        .abort      (abort_req),
        .state      (seq_state),
        .busy       (busy),
        .done_set   (done_set),
        .ld_weights (ld_weights),
        .ld_fifo    (ld_fifo),
        .mult_en    (mult_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            base_w_q   <= '0;
            base_in_q  <= '0;
            base_out_q <= '0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= bus.slave_writedata[CTRL_IRQ_EN_BIT];
            end
            // Completion beats a concurrent W1C
            if (done_set) begin
                done_q <= 1'b1;
            end else if (start_acc || (status_wr && bus.slave_writedata[STAT_DONE_BIT])) begin
                done_q <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (status_wr && bus.slave_writedata[STAT_ERR_BIT]) begin
                err_q <= 1'b0;
            end
            if (csr_wr && (csr_idx == CSR_BASE_W)) begin
                base_w_q <= (base_w_q & ~lane_mask) | (wd_bank & lane_mask);
            end
            if (csr_wr && (csr_idx == CSR_BASE_IN)) begin
                base_in_q <= (base_in_q & ~lane_mask) | (wd_bank & lane_mask);
            end
            if (csr_wr && (csr_idx == CSR_BASE_OUT)) begin
                base_out_q <= (base_out_q & ~lane_mask) | (wd_bank & lane_mask);
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_idx)
            CSR_CTRL:     csr_rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            CSR_STATUS: begin
                csr_rdata[STAT_BUSY_BIT]          = busy;
                csr_rdata[STAT_DONE_BIT]          = done_q;
                csr_rdata[STAT_ERR_BIT]           = err_q;
                csr_rdata[STAT_STATE_LSB +: 3]    = seq_state;
            end
            CSR_BASE_W:   csr_rdata[BANK_AW-1:0] = base_w_q;
            CSR_BASE_IN:  csr_rdata[BANK_AW-1:0] = base_in_q;
            CSR_BASE_OUT: csr_rdata[BANK_AW-1:0] = base_out_q;
            CSR_ID:       csr_rdata = DATA_WIDTH'(id_word(DIM));
            default:      csr_rdata = '0;
        endcase
    end

    // Output-region reads are served by the core one cycle later, so only the
    // select is registered here and the data is muxed in on the return cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q   <= '0;
            out_sel_q <= 1'b0;
        end else begin
            out_sel_q <= bus.slave_read && (region == REGION_OUTPUT);
            if (bus.slave_read) begin
                rdata_q <= (region == REGION_CSR) ? csr_rdata : '0;
            end
        end
    end

    assign bus.slave_readdata = out_sel_q ? rd_data_output : rdata_q;
    assign irq                = done_q & irq_en_q;
    assign base_addr_weights  = base_w_q;
    assign base_addr_input    = base_in_q;
    assign base_addr_output   = base_out_q;
endmodule
